// File: rtl/reg_write_seq.sv
// Host register-write sequencer: queues {addr,data} writes and replays them as one-cycle strobes.
// Define REG_WRITE_SEQ_VBLANK_GATE_EN to allow draining only while iVBLANK is high.
module reg_write_seq #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          iCLOCK,
   input  logic                          iRESET,
   input  logic [2:0]                    iHOST_ADDR,
   input  logic [31:0]                   iHOST_DATA,
   input  logic                          iHOST_VALID,
   output logic                          oHOST_READY,
   input  logic                          iVBLANK,
   output logic [2:0]                    oREG_ADDR,
   output logic [31:0]                   oREG_DATA,
   output logic                          oREG_WRITE,
   output logic [$clog2(FIFO_DEPTH):0]   oLEVEL,
   output logic                          oBUSY
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

   typedef enum logic {IDLE, DRAIN} state_t;

   typedef struct packed {
      logic [2:0]  addr;
      logic [31:0] data;
   } entry_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic [2:0]      reg_addr_q, reg_addr_d;
   logic [31:0]     reg_data_q, reg_data_d;
   logic            reg_write_q, reg_write_d;
   entry_t          mem_q [FIFO_DEPTH];

   logic gate;
   logic empty;
   logic push;
   logic pop;
   entry_t head;

`ifdef REG_WRITE_SEQ_VBLANK_GATE_EN
   assign gate = iVBLANK;
`else
   logic unused_vblank;
   assign gate          = 1'b1;
   assign unused_vblank = iVBLANK;
`endif

   assign empty       = (level_q == '0);
   // Full is judged on the registered level only, so a same-cycle pop never opens a full queue.
   assign oHOST_READY = !iRESET && (level_q < DEPTH_L);
   assign push        = iHOST_VALID && oHOST_READY;
   assign head        = mem_q[rd_ptr_q];

   // Pop is decided by the registered state, so a pop committed on the gate-closing edge still strobes.
   assign pop = (state_q == DRAIN) && !empty;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      reg_addr_d  = reg_addr_q;
      reg_data_d  = reg_data_q;
      reg_write_d = 1'b0;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d    = rd_ptr_q + PW'(1);
         reg_write_d = 1'b1;
         reg_addr_d  = head.addr;
         reg_data_d  = head.data;
      end

      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      unique case (state_q)
         IDLE:  if (!empty && gate) state_d = DRAIN;
         DRAIN: if (empty || !gate) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge iCLOCK) begin
      if (iRESET) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         reg_addr_q  <= '0;
         reg_data_q  <= '0;
         reg_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         reg_addr_q  <= reg_addr_d;
         reg_data_q  <= reg_data_d;
         reg_write_q <= reg_write_d;
      end
   end

   // NOTE: the storage array is not reset; level and pointers alone define which entries are valid.
   always_ff @(posedge iCLOCK) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{addr: iHOST_ADDR, data: iHOST_DATA};
      end
   end

   assign oREG_ADDR  = reg_addr_q;
   assign oREG_DATA  = reg_data_q;
   assign oREG_WRITE = reg_write_q;
   assign oLEVEL     = level_q;
   assign oBUSY      = !empty || reg_write_q;

endmodule

// File: tb/tb_reg_write_seq.sv
// Bench for reg_write_seq: a depth-8 and a depth-2 instance share stimulus and are
// compared every cycle against a queue-based reference model, plus directed sequences.
module tb_reg_write_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [2:0]  addr;
   logic [31:0] data;
   logic        vblank;

   logic        ra, wa, ba, rb, wb, bb;
   logic [2:0]  aa, ab;
   logic [31:0] da, db;
   logic [3:0]  la;
   logic [1:0]  lb;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   reg_write_seq #(.FIFO_DEPTH(8)) dut (
      .iCLOCK(clk), .iRESET(rst), .iHOST_ADDR(addr), .iHOST_DATA(data),
      .iHOST_VALID(valid), .oHOST_READY(ra), .iVBLANK(vblank),
      .oREG_ADDR(aa), .oREG_DATA(da), .oREG_WRITE(wa), .oLEVEL(la), .oBUSY(ba));

   reg_write_seq #(.FIFO_DEPTH(2)) dut2 (
      .iCLOCK(clk), .iRESET(rst), .iHOST_ADDR(addr), .iHOST_DATA(data),
      .iHOST_VALID(valid), .oHOST_READY(rb), .iVBLANK(vblank),
      .oREG_ADDR(ab), .oREG_DATA(db), .oREG_WRITE(wb), .oLEVEL(lb), .oBUSY(bb));

   typedef struct packed {
      logic [2:0]  addr;
      logic [31:0] data;
   } entry_t;

   // Reference model: a plain queue per instance plus a "draining" flag.
   entry_t      mq [2][$];
   bit          m_drain [2];
   logic        m_w [2];
   logic [2:0]  m_a [2];
   logic [31:0] m_d [2];
   int          depth [2] = '{8, 2};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit gate_open();
`ifdef REG_WRITE_SEQ_VBLANK_GATE_EN
      return vblank;
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_update();
      int     sz;
      entry_t e;
      for (int k = 0; k < 2; k++) begin
         sz = mq[k].size();
         if (rst) begin
            mq[k].delete();
            m_drain[k] = 0;
            m_w[k] = 0; m_a[k] = '0; m_d[k] = '0;
         end else begin
            m_w[k] = 0;
            if (m_drain[k] && sz != 0) begin
               e = mq[k].pop_front();
               m_w[k] = 1; m_a[k] = e.addr; m_d[k] = e.data;
            end
            m_drain[k] = (sz != 0) && gate_open();
            if (valid && sz < depth[k]) mq[k].push_back('{addr: addr, data: data});
         end
      end
   endtask

   task automatic model_compare();
      int sz;
      for (int k = 0; k < 2; k++) begin
         sz = mq[k].size();
         check($sformatf("m%0d_write", k), (k == 0) ? wa : wb, m_w[k]);
         check($sformatf("m%0d_addr", k),  (k == 0) ? aa : ab, m_a[k]);
         check($sformatf("m%0d_data", k),  (k == 0) ? da : db, m_d[k]);
         check($sformatf("m%0d_level", k), (k == 0) ? la : 4'(lb), sz);
         check($sformatf("m%0d_ready", k), (k == 0) ? ra : rb, !rst && sz < depth[k]);
         check($sformatf("m%0d_busy", k),  (k == 0) ? ba : bb, (sz != 0) || m_w[k]);
      end
   endtask

   // One clock: inputs are stable across the edge, outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      model_compare();
   endtask

   task automatic drive(input bit v, input logic [2:0] a, input logic [31:0] d);
      valid = v; addr = a; data = d;
   endtask

   typedef struct {
      bit          v;
      logic [2:0]  a;
      logic [31:0] d;
      bit          ew;
      logic [2:0]  ea;
      logic [31:0] ed;
      int          el;
      bit          eb;
   } vec_t;

   vec_t tbl [10];
   int   cnt;
   int   idx;

   initial begin
      tbl[0] = '{1, 3'd1, 32'h1,        0, 3'd0, 32'h0,        1, 1};
      tbl[1] = '{1, 3'd2, 32'h2,        0, 3'd0, 32'h0,        2, 1};
      tbl[2] = '{0, 3'd0, 32'h0,        1, 3'd1, 32'h1,        1, 1};
      tbl[3] = '{1, 3'd7, 32'hDEADBEEF, 1, 3'd2, 32'h2,        1, 1};
      tbl[4] = '{0, 3'd0, 32'h0,        1, 3'd7, 32'hDEADBEEF, 0, 1};
      tbl[5] = '{0, 3'd0, 32'h0,        0, 3'd7, 32'hDEADBEEF, 0, 0};
      tbl[6] = '{1, 3'd3, 32'h33,       0, 3'd7, 32'hDEADBEEF, 1, 1};
      tbl[7] = '{0, 3'd0, 32'h0,        0, 3'd7, 32'hDEADBEEF, 1, 1};
      tbl[8] = '{0, 3'd0, 32'h0,        1, 3'd3, 32'h33,       0, 1};
      tbl[9] = '{0, 3'd0, 32'h0,        0, 3'd3, 32'h33,       0, 0};

      for (int k = 0; k < 2; k++) begin
         m_drain[k] = 0; m_w[k] = 0; m_a[k] = '0; m_d[k] = '0;
      end
      rst = 1'b1; vblank = 1'b0;
      drive(1, 3'd5, 32'h55);
      repeat (3) step();
      check("rst_ready", ra, 0);
      check("rst_level", la, 0);
      check("rst_write", wa, 0);
      check("rst_busy", ba, 0);
      rst = 1'b0;
      drive(0, 0, 0);
      vblank = 1'b1;
      step();
      check("ready_after_rst", ra, 1);

      // Two back-to-back writes, a queued third, then an isolated single write.
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].v, tbl[i].a, tbl[i].d);
         step();
         check($sformatf("tbl%0d_write", i), wa, tbl[i].ew);
         check($sformatf("tbl%0d_addr", i),  aa, tbl[i].ea);
         check($sformatf("tbl%0d_data", i),  da, tbl[i].ed);
         check($sformatf("tbl%0d_level", i), la, tbl[i].el);
         check($sformatf("tbl%0d_busy", i),  ba, tbl[i].eb);
         check($sformatf("tbl%0d_ready", i), ra, 1);
      end

`ifndef REG_WRITE_SEQ_VBLANK_GATE_EN
      // Gate ignores iVBLANK: a write still lands with vblank held low.
      vblank = 1'b0;
      drive(1, 3'd7, 32'hDEADBEEF);
      step();
      drive(0, 0, 0);
      step();
      check("novb_lat1_write", wa, 0);
      step();
      check("novb_write", wa, 1);
      check("novb_addr", aa, 3'd7);
      check("novb_data", da, 32'hDEADBEEF);
      repeat (2) step();
`else
      // Closed gate: fill the queue, ninth push is refused, then drain in order.
      vblank = 1'b0;
      for (int i = 0; i < 9; i++) begin
         drive(1, 3'(i), 32'h100 + i);
         step();
      end
      drive(0, 0, 0);
      check("full_level", la, 8);
      check("full_ready", ra, 0);
      vblank = 1'b1;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (wa) begin
            check($sformatf("fill_addr%0d", cnt), aa, 3'(cnt));
            check($sformatf("fill_data%0d", cnt), da, 32'h100 + cnt);
            cnt++;
         end
      end
      check("fill_strobes", cnt, 8);
      check("fill_level", la, 0);
      check("fill_busy", ba, 0);

      // Short blanking window: only strobes committed inside it come out.
      vblank = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1, 3'(i + 2), 32'h300 + i);
         step();
      end
      drive(0, 0, 0);
      vblank = 1'b1;
      cnt = 0;
      repeat (2) begin step(); if (wa) cnt++; end
      vblank = 1'b0;
      repeat (4) begin step(); if (wa) cnt++; end
      check("window_le3", cnt <= 3, 1);
      check("window_retained", la, 4 - cnt);
      vblank = 1'b1;
      repeat (8) begin step(); if (wa) cnt++; end
      check("window_total", cnt, 4);
      check("window_level", la, 0);
`endif

      // Reset in the middle of a drain, then a normal-latency write.
`ifdef REG_WRITE_SEQ_VBLANK_GATE_EN
      vblank = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1, 3'(i), 32'h400 + i);
         step();
      end
      drive(0, 0, 0);
      vblank = 1'b1;
      repeat (2) step();
`else
      vblank = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1, 3'(i), 32'h400 + i);
         step();
      end
      drive(0, 0, 0);
`endif
      rst = 1'b1;
      step();
      check("midrst_write", wa, 0);
      check("midrst_level", la, 0);
      check("midrst_addr", aa, 0);
      check("midrst_data", da, 0);
      rst = 1'b0;
      step();
      check("midrst_next_write", wa, 0);
      drive(1, 3'd4, 32'hABC);
      step();
      drive(0, 0, 0);
      check("relat_level", la, 1);
      step();
      check("relat_lat1", wa, 0);
      step();
      check("relat_write", wa, 1);
      check("relat_addr", aa, 3'd4);
      check("relat_data", da, 32'hABC);

      // Continuous pushing while draining; the depth-2 instance hits full.
      rst = 1'b1; step(); rst = 1'b0; step();
      vblank = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1, 3'(i), 32'h200 + i);
         step();
         if (i == 1) begin
            check("d2_full_level", lb, 2);
            check("d2_full_ready", rb, 0);
         end
         if (i == 2) check("d2_no_passthru", lb, 1);
         if (i == 7) check("steady_level", la, 2);
      end
      drive(0, 0, 0);
      repeat (4) step();

      // Randomized traffic against the model.
      for (int i = 0; i < 800; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 7) == 0) vblank = ~vblank;
         drive($urandom_range(0, 9) < 7, 3'($urandom), $urandom);
         step();
      end
      rst = 1'b0;
      drive(0, 0, 0);
      vblank = 1'b1;
      idx = 0;
      repeat (20) begin step(); idx++; end
      check("final_level", la, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
